clk_freq_meter: RTL and testbench
=================================

Name: clk_freq_meter

Overview:
- Measures the frequency of an asynchronous test signal (e.g. the divided 1 MHz OLED clock) by counting its rising edges during a fixed gate window of system clk cycles.
- Serves as the inverse of the clock divider: self-check/debug block alongside the OLED clocking path.
- Result is published with a one-cycle valid pulse.
- Supports single-shot and continuous modes.

Parameters:
- GATE_CYCLES, 50_000_000, gate window length in clk cycles (1 s at 50 MHz); must be ≥ 2.
- CNT_W, 26, width of edge counter and result.
- SYNC_STAGES, 2, synchronizer flops on sig_in; must be ≥ 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin one measurement window
- cont_en  in  1  continuous mode: windows restart back-to-back while high
- sig_in  in  1  asynchronous signal under test; frequency must be < clk/4
- busy  out  1  high while a window is open or the result is being published
- freq_cnt  out  CNT_W  rising edges counted in the last completed window
- valid  out  1  one-cycle pulse when freq_cnt updates
- overflow  out  1  last window saturated the edge counter
- high_cnt  out  CNT_W  clk cycles with synced sig_in high in last window (see Optional Feature)

Behaviour:
- Reset: rst_n asynchronous active-low, clock clk. All flops clear.
  - freq_cnt=0, high_cnt=0, valid=0, overflow=0, busy=0.
  - State=IDLE, synchronizer and edge-detect history=0.
- Synchronizer and edge detector run in every state.
  - rise = sync_out & ~prev.
  - Latency from a sig_in rising edge to rise: SYNC_STAGES+1 clk cycles.
- FSM states: IDLE, GATE, DONE.
  - IDLE -> GATE when start=1 or cont_en=1. On entry: gate_cnt=0, edge_cnt=0, sat=0.
  - GATE:
    - gate_cnt increments each cycle.
    - edge_cnt increments on rise, saturating at 2^CNT_W-1. Setting sat happens when an increment is attempted at max.
    - A rise in the final gate cycle is counted.
    - After exactly GATE_CYCLES cycles in GATE (gate_cnt==GATE_CYCLES-1) -> DONE.
  - DONE (1 cycle):
    - freq_cnt<=edge_cnt, overflow<=sat, valid=1.
    - Next state is GATE (counters re-cleared) if cont_en=1, else IDLE.
- busy=1 in GATE and DONE.
- valid timing:
  - Single shot: valid asserts GATE_CYCLES+1 cycles after the cycle start is sampled.
  - Continuous mode: valid period is GATE_CYCLES+1.
- start while busy: ignored, not queued.
- cont_en dropped mid-window: current window completes and publishes, then IDLE.
- freq_cnt/overflow hold their value until the next DONE. They are not cleared on start.
- Reset mid-window: immediate return to reset values. No valid pulse.
- Edges present before GATE entry are not counted. Only rises detected while in GATE are counted.
- Frequency in Hz = freq_cnt × clk_freq / GATE_CYCLES. Computed by software, not in RTL.

Optional Feature:
- Macro: CLK_FREQ_METER_DUTY_EN.
- Defined:
  - A second saturating counter counts GATE cycles with sync_out=1.
  - It is latched to high_cnt in DONE, alongside freq_cnt.
- Undefined:
  - Counter not built; high_cnt tied to 0.
  - Port list unchanged.

Decomposition:
- Package clk_meas_pkg: FSM state enum (IDLE/GATE/DONE), default constants DEF_GATE_CYCLES, DEF_CNT_W, DEF_SYNC_STAGES.
- Sub-module sig_sync_edge: SYNC_STAGES-flop synchronizer plus rising-edge detector; outputs sync_out and rise.

Test Plan:
- Reset: assert rst_n=0 mid-simulation -> all outputs 0, busy=0, no valid for ≥ 20 cycles after release with start=0.
- Single shot: GATE_CYCLES=1000, sig_in period 50 clk cycles (50% duty), pulse start -> one valid exactly 1001 cycles later with freq_cnt=20, overflow=0, busy falls the cycle after valid.
- Static input: sig_in held 1 through a window -> freq_cnt=0. With DUTY_EN defined, high_cnt=1000.
- Saturation: CNT_W=4, GATE_CYCLES=1000, sig_in period 4 cycles -> freq_cnt=15, overflow=1. Next window with sig_in period 100 -> freq_cnt=10, overflow=0.
- Continuous: cont_en=1, period 50 -> valid every 1001 cycles, each freq_cnt in {19,20,21}. Drop cont_en mid-window -> exactly one more valid, then IDLE. A start pulse during GATE has no effect.
- Reset mid-window: pull rst_n low at cycle 500 of a window -> no valid; freq_cnt=0 after release. New start gives the correct count of 20.

Source files
------------

// File: rtl/clk_meas_pkg.sv
// Shared types and default constants for the clock frequency meter.
package clk_meas_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        DONE = 2'd2
    } meas_state_e;

    // 1 s gate at a 50 MHz system clock
    localparam int DEF_GATE_CYCLES = 50_000_000;
    localparam int DEF_CNT_W       = 26;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sig_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input followed by a
// registered rising-edge detector. The rise pulse appears SYNC_STAGES+1
// clk cycles after the input edge.
module sig_sync_edge
    import clk_meas_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;

    // Shift the input through the chain and compare against last value
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Synchronizer, history and edge pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = rise_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an asynchronous signal over a fixed gate window
// of clk cycles and publishes the count with a one-cycle valid pulse.
// Optional duty measurement (high-time counter) is built when the macro
// CLK_FREQ_METER_DUTY_EN is defined; otherwise high_cnt is tied to 0.
module clk_freq_meter
    import clk_meas_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont_en,
    input  logic             sig_in,
    output logic             busy,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             valid,
    output logic             overflow,
    output logic [CNT_W-1:0] high_cnt
);

    localparam int               GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    meas_state_e      state_q, state_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_cnt_q, freq_cnt_d;
    logic             overflow_q, overflow_d;
    logic             valid_q, valid_d;
    logic             sync_out;
    logic             rise;
    logic             win_open;

    sig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .sync_out (sync_out),
        .rise     (rise)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a new window is not accepted during the publish cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if ((start || cont_en) && !valid_q) state_d = GATE;
            GATE: if (gate_cnt_q == GATE_LAST)        state_d = DONE;
            DONE: state_d = cont_en ? GATE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window opens whenever we are about to enter GATE from another state
    assign win_open = (state_d == GATE) && (state_q != GATE);

    // Gate/edge counters and the published result registers
    always_comb begin
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        freq_cnt_d = freq_cnt_q;
        overflow_d = overflow_q;
        valid_d    = (state_q == DONE);
        if (win_open) begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            sat_d      = 1'b0;
        end else if (state_q == GATE) begin
            gate_cnt_d = gate_cnt_q + GW'(1);
            if (rise) begin
                if (edge_cnt_q == CNT_MAX) begin
                    sat_d = 1'b1;
                end else begin
                    edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
            end
        end
        if (state_q == DONE) begin
            freq_cnt_d = edge_cnt_q;
            overflow_d = sat_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_cnt_q <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sat_q      <= sat_d;
            freq_cnt_q <= freq_cnt_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

`ifdef CLK_FREQ_METER_DUTY_EN
    logic [CNT_W-1:0] high_acc_q, high_acc_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;

    // Saturating count of gate cycles with the synced input high
    always_comb begin
        high_acc_d = high_acc_q;
        high_cnt_d = high_cnt_q;
        if (win_open) begin
            high_acc_d = '0;
        end else if ((state_q == GATE) && sync_out && (high_acc_q != CNT_MAX)) begin
            high_acc_d = high_acc_q + CNT_W'(1);
        end
        if (state_q == DONE) begin
            high_cnt_d = high_acc_q;
        end
    end

    // Duty counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_acc_q <= '0;
            high_cnt_q <= '0;
        end else begin
            high_acc_q <= high_acc_d;
            high_cnt_q <= high_cnt_d;
        end
    end

    assign high_cnt = high_cnt_q;
`else
    logic unused_sync_out;
    assign unused_sync_out = sync_out;
    assign high_cnt        = '0;
`endif

    // Outputs: busy covers the open window and the publish cycle
    always_comb begin
        busy     = (state_q != IDLE) || valid_q;
        valid    = valid_q;
        freq_cnt = freq_cnt_q;
        overflow = overflow_q;
    end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Scoreboard bench for clk_freq_meter: expected window results are
// computed from a behavioural model of the test signal and queued when a
// window is requested; a monitor compares on every valid pulse.
module tb_clk_freq_meter;

    localparam int G    = 1000;
    localparam int W    = 5;
    localparam int SYNC = 2;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cont_en = 1'b0;
    logic         sig_in = 1'b0;
    logic         busy;
    logic [W-1:0] freq_cnt;
    logic         valid;
    logic         overflow;
    logic [W-1:0] high_cnt;

    clk_freq_meter #(
        .GATE_CYCLES (G),
        .CNT_W       (W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cont_en  (cont_en),
        .sig_in   (sig_in),
        .busy     (busy),
        .freq_cnt (freq_cnt),
        .valid    (valid),
        .overflow (overflow),
        .high_cnt (high_cnt)
    );

    always #5 clk = ~clk;

    // Posedge index; at a negedge, cyc names the posedge just passed
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Test-signal description: periodic square wave or static level
    int sigPer = 50;
    int sigPh = 0;
    bit sigStatic = 1'b0;
    bit sigLvl = 1'b0;

    function automatic bit sigAt(int k);
        if (sigStatic) return sigLvl;
        return ((k + sigPh) % sigPer) < (sigPer / 2);
    endfunction

    // Drive the value that the next posedge will sample
    always @(negedge clk) sig_in = sigAt(cyc + 1);

    typedef struct {
        int cycAt;
        int cnt;
        bit ovf;
        int high;
        bit last;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   passed = 0;
    bit   busyPending = 1'b0;

    task automatic checkOutput(input string name, input longint act, input longint expv);
        total++;
        if (act == expv) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Window starting at posedge s: a signal edge sampled at posedge k is
    // seen as a rise SYNC+1 cycles later and counted if that lands on one of
    // the G gate posedges s+1..s+G.
    function automatic exp_t modelWindow(int s, bit last);
        exp_t e;
        int   n = 0;
        int   h = 0;
        for (int k = s + 1 - (SYNC + 1); k <= s + G - (SYNC + 1); k++)
            if (sigAt(k) && !sigAt(k - 1)) n++;
        for (int j = s + 1; j <= s + G; j++)
            if (sigAt(j - SYNC)) h++;
        e.cycAt = s + G + 1;
        e.cnt   = (n > MAXV) ? MAXV : n;
        e.ovf   = (n > MAXV);
`ifdef CLK_FREQ_METER_DUTY_EN
        e.high  = (h > MAXV) ? MAXV : h;
`else
        e.high  = 0;
`endif
        e.last  = last;
        return e;
    endfunction

    // Monitor: compare every published result against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (busyPending) begin
                checkOutput("busy_after_last_valid", busy, 0);
                busyPending = 1'b0;
            end
            if (valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    $display("[TB] FAIL unexpected_valid: got valid=1 freq_cnt=%0d, expected no pulse (cycle %0d)", freq_cnt, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput("valid_cycle", cyc, e.cycAt);
                    checkOutput("freq_cnt", freq_cnt, e.cnt);
                    checkOutput("overflow", overflow, e.ovf);
                    checkOutput("high_cnt", high_cnt, e.high);
                    checkOutput("busy_at_valid", busy, 1);
                    busyPending = e.last;
                end
            end
        end
    end

    task automatic setPeriodic(input int per, input bit randPhase);
        sigStatic = 1'b0;
        sigPer    = per;
        sigPh     = randPhase ? int'($urandom_range(0, per - 1)) : 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic setStatic(input bit lvl);
        sigStatic = 1'b1;
        sigLvl    = lvl;
        repeat (10) @(negedge clk);
    endtask

    // Single-shot request: pulse start and queue the expected result
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        sbq.push_back(modelWindow(cyc + 1, 1'b1));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            total++;
            $display("[TB] FAIL drain_timeout: %0d results still pending, expected 0", sbq.size());
            sbq.delete();
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_freq_cnt"}, freq_cnt, 0);
        checkOutput({tag, "_high_cnt"}, high_cnt, 0);
        checkOutput({tag, "_valid"}, valid, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int s;
        $display("[TB] clk_freq_meter bench start");
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single shot, period 50 -> 20 edges
        setPeriodic(50, 1'b1);
        applyStimulus();
        waitDrain(G + 50);

        // Static high input -> no edges
        setStatic(1'b1);
        applyStimulus();
        waitDrain(G + 50);

        // Saturation with period 4, then recovery with period 100
        setPeriodic(4, 1'b1);
        applyStimulus();
        waitDrain(G + 50);
        setPeriodic(100, 1'b1);
        applyStimulus();
        waitDrain(G + 50);

        // Randomized periods and phases
        for (int i = 0; i < 4; i++) begin
            setPeriodic(int'($urandom_range(4, 120)), 1'b1);
            applyStimulus();
            waitDrain(G + 50);
        end

        // Continuous mode: four windows, stray start mid-window, then drop
        setPeriodic(50, 1'b1);
        @(negedge clk);
        cont_en = 1'b1;
        s = cyc + 1;
        for (int w = 0; w < 4; w++)
            sbq.push_back(modelWindow(s + w * (G + 1), w == 3));
        for (int i = 0; i < 5 * G && cyc < s + 3 * (G + 1) + 500; i++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cont_en = 1'b0;
        waitDrain(2 * G);
        repeat (G + 50) @(negedge clk);
        checkOutput("idle_after_cont", busy, 0);

        // Reset in the middle of a window
        setPeriodic(50, 1'b1);
        applyStimulus();
        repeat (500) @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        busyPending = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("midreset");
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        checkResetOutputs("post_reset");
        applyStimulus();
        waitDrain(G + 50);

        checkOutput("queue_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
